// File: rtl/uart_rx_pkt_ctrl.sv
// Sequencer for a UART receiver: programmable oversample tick, SOF/LEN/payload/checksum
// framing into a payload buffer, valid/ack hand-off, and error reporting.
module uart_rx_pkt_ctrl #(
  parameter int unsigned DIV_W         = 16,
  parameter int unsigned DIV_DEFAULT   = 163,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned LEN_W         = 5,
  parameter logic [7:0]  SOF           = 8'hA5,
  parameter int unsigned TIMEOUT_TICKS = 640
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_load,
  output logic              s_tick,
  input  logic              rx_done_tick,
  input  logic [7:0]        rx_dout,
  output logic              pkt_valid,
  output logic [LEN_W-1:0]  pkt_len,
  input  logic              pkt_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              err_pulse,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam int unsigned ToW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [1:0] ErrLen     = 2'd0;
  localparam logic [1:0] ErrTimeout = 2'd1;
  localparam logic [1:0] ErrChk     = 2'd2;
  localparam logic [1:0] ErrOverrun = 2'd3;

  typedef enum logic [2:0] {StIdle, StLen, StPayload, StChk, StHold} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, cnt_q;
  logic             s_tick_q;
  logic [ToW-1:0]   to_q, to_d;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d, pkt_len_q, pkt_len_d;
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       rd_data_q;
  logic             err_pulse_q, err_d;
  logic [1:0]       err_code_q, code_d;
  logic             buf_we, cfg_ok, active, timeout, len_ok;
  logic [7:0]       mem [MAX_LEN];

  assign pkt_valid = (state_q == StHold);
  assign busy      = (state_q != StIdle);
  assign s_tick    = s_tick_q;
  assign pkt_len   = pkt_len_q;
  assign rd_data   = rd_data_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;

  assign cfg_ok  = cfg_load && (state_q == StIdle) && !pkt_valid;
  assign active  = (state_q == StLen) || (state_q == StPayload) || (state_q == StChk);
  // A byte landing on the final tick wins over the timeout.
  assign timeout = active && s_tick_q && !rx_done_tick && (to_q == ToW'(TIMEOUT_TICKS - 1));
  assign len_ok  = (rx_dout != 8'd0) && (rx_dout <= 8'(MAX_LEN));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q    <= DIV_W'(DIV_DEFAULT);
      cnt_q    <= '0;
      s_tick_q <= 1'b0;
    end else if (cfg_ok) begin
      div_q    <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
      cnt_q    <= '0;
      s_tick_q <= 1'b0;
    end else begin
      s_tick_q <= (cnt_q == div_q);
      cnt_q    <= (cnt_q == div_q) ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    pkt_len_d = pkt_len_q;
    err_d     = 1'b0;
    code_d    = err_code_q;
    buf_we    = 1'b0;
    to_d      = (!active || rx_done_tick) ? '0 : (s_tick_q ? to_q + ToW'(1) : to_q);
    unique case (state_q)
      StIdle: begin
        if (rx_done_tick && (rx_dout == SOF)) state_d = StLen;
      end
      StLen: begin
        if (rx_done_tick) begin
          if (len_ok) begin
            len_d   = rx_dout[LEN_W-1:0];
            sum_d   = rx_dout;
            idx_d   = '0;
            state_d = StPayload;
          end else begin
            err_d   = 1'b1;
            code_d  = ErrLen;
            state_d = StIdle;
          end
        end
      end
      StPayload: begin
        if (rx_done_tick) begin
          buf_we = 1'b1;
          sum_d  = sum_q + rx_dout;
          idx_d  = idx_q + LEN_W'(1);
          if (idx_q == len_q - LEN_W'(1)) state_d = StChk;
        end
      end
      StChk: begin
        if (rx_done_tick) begin
          if (rx_dout == sum_q) begin
            pkt_len_d = len_q;
            state_d   = StHold;
          end else begin
            err_d   = 1'b1;
            code_d  = ErrChk;
            state_d = StIdle;
          end
        end
      end
      StHold: begin
        if (rx_done_tick) begin
          err_d  = 1'b1;
          code_d = ErrOverrun;
        end
        if (pkt_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (timeout) begin
      err_d   = 1'b1;
      code_d  = ErrTimeout;
      state_d = StIdle;
      to_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      to_q        <= '0;
      pkt_len_q   <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= 2'd0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      to_q        <= to_d;
      pkt_len_q   <= pkt_len_d;
      err_pulse_q <= err_d;
      err_code_q  <= code_d;
      rd_data_q   <= mem[rd_addr];
    end
  end

  // Payload storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (buf_we) mem[ADDR_W'(idx_q)] <= rx_dout;
  end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Self-checking bench for uart_rx_pkt_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a byte-level packet model.
module tb_uart_rx_pkt_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cfg_div = '0;
  logic        cfg_load = 1'b0;
  logic        rx_done_tick = 1'b0;
  logic [7:0]  rx_dout = '0;
  logic        pkt_ack = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        s_tick, pkt_valid, err_pulse, busy;
  logic [4:0]  pkt_len;
  logic [7:0]  rd_data;
  logic [1:0]  err_code;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_rx_pkt_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_div      (cfg_div),
    .cfg_load     (cfg_load),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .pkt_valid    (pkt_valid),
    .pkt_len      (pkt_len),
    .pkt_ack      (pkt_ack),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .err_pulse    (err_pulse),
    .err_code     (err_code),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (byte/packet level) ----------------
  int unsigned m_n, m_origin, m_div, m_err_code, m_pkt_len, m_silent, s_code, s_sum;
  bit          m_tick, m_in_frame, m_hold, m_err_pulse, m_rd_chk, s_idle, s_err, s_tick_now;
  logic [7:0]  m_rd_exp;
  logic [7:0]  m_buf [16];
  logic [7:0]  m_frame [$];

  task automatic model_reset();
    m_n = 0; m_origin = 0; m_div = 163; m_tick = 0;
    m_in_frame = 0; m_hold = 0; m_err_pulse = 0; m_err_code = 0;
    m_pkt_len = 0; m_silent = 0; m_rd_chk = 0; m_rd_exp = '0;
    m_frame.delete();
  endtask

  always @(negedge reset) model_reset();

  always @(posedge clk) begin
    if (reset) begin
      s_tick_now = m_tick;
      s_idle     = !m_in_frame && !m_hold;
      s_err      = 0;
      s_code     = 0;
      m_rd_chk   = m_hold && (rd_addr < m_pkt_len);
      m_rd_exp   = m_buf[rd_addr];
      m_n++;
      if (m_hold) begin
        if (rx_done_tick) begin s_err = 1; s_code = 3; end
        if (pkt_ack) m_hold = 0;
      end else if (m_in_frame) begin
        if (rx_done_tick) begin
          m_silent = 0;
          m_frame.push_back(rx_dout);
          if (m_frame.size() == 1) begin
            if (rx_dout == 0 || rx_dout > 16) begin s_err = 1; s_code = 0; m_in_frame = 0; end
          end else if (m_frame.size() == m_frame[0] + 2) begin
            s_sum = 0;
            for (int i = 0; i < m_frame.size() - 1; i++) s_sum += m_frame[i];
            m_in_frame = 0;
            if (rx_dout == (s_sum % 256)) begin
              m_hold    = 1;
              m_pkt_len = m_frame[0];
              for (int i = 0; i < m_pkt_len; i++) m_buf[i] = m_frame[i+1];
            end else begin
              s_err = 1; s_code = 2;
            end
          end
        end else if (s_tick_now) begin
          m_silent++;
          if (m_silent == 640) begin s_err = 1; s_code = 1; m_in_frame = 0; end
        end
      end else if (rx_done_tick && rx_dout == 8'hA5) begin
        m_in_frame = 1;
        m_frame.delete();
        m_silent = 0;
      end
      if (cfg_load && s_idle) begin
        m_div    = (cfg_div == 0) ? 1 : cfg_div;
        m_origin = m_n;
        m_tick   = 0;
      end else begin
        m_tick = ((m_n - m_origin) % (m_div + 1)) == 0;
      end
      m_err_pulse = s_err;
      if (s_err) m_err_code = s_code;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("s_tick", s_tick, m_tick);
      check("pkt_valid", pkt_valid, m_hold);
      check("busy", busy, m_in_frame || m_hold);
      check("err_pulse", err_pulse, m_err_pulse);
      check("err_code", err_code, m_err_code);
      if (m_hold) check("pkt_len", pkt_len, m_pkt_len);
      if (m_rd_chk) check("rd_data", rd_data, m_rd_exp);
    end
  end

  // ---------------- stimulus helpers (all called at a negedge) ----------------
  task automatic wait_cyc(input int n);
    repeat (n) begin rd_addr = 4'($urandom); @(negedge clk); end
  endtask

  task automatic send(input logic [7:0] b);
    rx_done_tick = 1'b1; rx_dout = b;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b, input int g);
    send(b); wait_cyc(g);
  endtask

  task automatic load(input logic [15:0] d);
    cfg_div = d; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic ack();
    pkt_ack = 1'b1;
    @(negedge clk);
    pkt_ack = 1'b0;
  endtask

  task automatic measure_period(output int p);
    int c;
    p = -1; c = 0;
    while (!s_tick && c < 2000) begin @(negedge clk); c++; end
    if (s_tick) begin
      @(negedge clk); c = 1;
      while (!s_tick && c < 2000) begin @(negedge clk); c++; end
      if (s_tick) p = c;
    end
  endtask

  task automatic read_chk(input logic [3:0] a, input logic [7:0] exp, input string name);
    rd_addr = a;
    @(negedge clk);
    check(name, rd_data, exp);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 4000) begin wait_cyc(1); c++; end
    check("idle_after_timeout", busy, 0);
  endtask

  task automatic rand_packet(input bit bad_chk, input bit trunc);
    int len, n;
    logic [7:0] sum, b;
    len = $urandom_range(1, 16);
    n = trunc ? $urandom_range(0, len - 1) : len;
    send_gap(8'hA5, $urandom_range(0, 3));
    sum = 8'(len);
    send_gap(8'(len), $urandom_range(0, 3));
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      sum += b;
      send_gap(b, $urandom_range(0, 3));
    end
    if (trunc) wait_idle();
    else send(bad_chk ? sum + 8'd1 : sum);
  endtask

  task automatic hold_and_release();
    wait_cyc($urandom_range(0, 4));
    if ($urandom_range(0, 3) == 0) load(16'd7);
    if ($urandom_range(0, 3) == 0) send(8'($urandom));
    pkt_ack = 1'b1;
    if ($urandom_range(0, 2) == 0) begin rx_done_tick = 1'b1; rx_dout = 8'($urandom); end
    @(negedge clk);
    pkt_ack = 1'b0; rx_done_tick = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, cnt, c, kind;
    logic [7:0] b;
    model_reset();
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_s_tick", s_tick, 0);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_pkt_len", pkt_len, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_code", err_code, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;

    measure_period(p);
    check("period_default", p, 164);
    load(16'd3);
    measure_period(p);
    check("period_div3", p, 4);
    load(16'd0);
    measure_period(p);
    check("period_div0_clamped", p, 2);

    // good packet
    send_gap(8'hA5, 2); send_gap(8'h03, 2); send_gap(8'h10, 2);
    send_gap(8'h20, 2); send_gap(8'h30, 2); send(8'h63);
    check("good_valid", pkt_valid, 1);
    check("good_len", pkt_len, 3);
    read_chk(4'd0, 8'h10, "good_rd0");
    read_chk(4'd1, 8'h20, "good_rd1");
    read_chk(4'd2, 8'h30, "good_rd2");
    ack();
    check("ack_valid", pkt_valid, 0);
    check("ack_busy", busy, 0);

    // bad checksum, bad lengths, garbage
    send_gap(8'hA5, 1); send_gap(8'h02, 1); send_gap(8'h01, 1); send_gap(8'h02, 1);
    send(8'h00);
    check("chk_err_pulse", err_pulse, 1);
    check("chk_err_code", err_code, 2);
    check("chk_valid", pkt_valid, 0);
    wait_cyc(1);
    check("chk_pulse_once", err_pulse, 0);
    send_gap(8'hA5, 1); send(8'h00);
    check("len0_pulse", err_pulse, 1);
    check("len0_code", err_code, 0);
    wait_cyc(1);
    send_gap(8'hA5, 1); send(8'h11);
    check("len17_pulse", err_pulse, 1);
    check("len17_code", err_code, 0);
    wait_cyc(1);
    send(8'h55);
    check("garbage_pulse", err_pulse, 0);
    check("garbage_busy", busy, 0);

    // timeout after 640 silent ticks
    send_gap(8'hA5, 1); send_gap(8'h04, 1); send(8'h01);
    cnt = 0; c = 0;
    while (!err_pulse && c < 4000) begin
      if (s_tick) cnt++;
      @(negedge clk); c++;
    end
    check("timeout_pulse", err_pulse, 1);
    check("timeout_ticks", cnt, 640);
    check("timeout_code", err_code, 1);
    check("timeout_busy", busy, 0);

    // byte exactly on the 640th tick is accepted
    send_gap(8'hA5, 1); send_gap(8'h04, 1); send(8'h01);
    cnt = 0; c = 0;
    while (c < 4000) begin
      if (s_tick) begin
        cnt++;
        if (cnt == 640) break;
      end
      @(negedge clk); c++;
    end
    check("edge_tick_found", cnt, 640);
    send(8'h02);
    check("edge_no_err", err_pulse, 0);
    check("edge_busy", busy, 1);
    send_gap(8'h03, 1); send_gap(8'h04, 1); send(8'h0E);
    check("edge_valid", pkt_valid, 1);
    check("edge_code_held", err_code, 1);

    // overrun while held, then overrun together with ack
    send(8'h77);
    check("ovr_pulse", err_pulse, 1);
    check("ovr_code", err_code, 3);
    check("ovr_valid", pkt_valid, 1);
    read_chk(4'd0, 8'h01, "ovr_rd0");
    read_chk(4'd1, 8'h02, "ovr_rd1");
    read_chk(4'd2, 8'h03, "ovr_rd2");
    read_chk(4'd3, 8'h04, "ovr_rd3");
    pkt_ack = 1'b1; rx_done_tick = 1'b1; rx_dout = 8'h77;
    @(negedge clk);
    pkt_ack = 1'b0; rx_done_tick = 1'b0;
    check("ovr_ack_pulse", err_pulse, 1);
    check("ovr_ack_code", err_code, 3);
    check("ovr_ack_valid", pkt_valid, 0);
    check("ovr_ack_busy", busy, 0);

    // divisor lockout while busy and while holding
    send(8'hA5);
    load(16'd9);
    measure_period(p);
    check("lock_busy_period", p, 2);
    send_gap(8'h01, 1); send_gap(8'hAA, 1); send(8'hAB);
    check("lock_valid", pkt_valid, 1);
    load(16'd9);
    measure_period(p);
    check("lock_hold_period", p, 2);
    ack();

    // asynchronous reset in the middle of a payload
    send_gap(8'hA5, 1); send_gap(8'h03, 1); send(8'h11);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", pkt_valid, 0);
    check("mid_rst_len", pkt_len, 0);
    check("mid_rst_code", err_code, 0);
    check("mid_rst_pulse", err_pulse, 0);
    check("mid_rst_tick", s_tick, 0);
    check("mid_rst_rd", rd_data, 0);
    @(negedge clk);
    reset = 1'b1;
    send_gap(8'hA5, 1); send_gap(8'h02, 1); send_gap(8'h05, 1); send_gap(8'h06, 1);
    send(8'h0D);
    check("post_rst_valid", pkt_valid, 1);
    check("post_rst_len", pkt_len, 2);
    read_chk(4'd0, 8'h05, "post_rst_rd0");
    read_chk(4'd1, 8'h06, "post_rst_rd1");
    ack();

    // randomized traffic, checked every cycle by the model
    load(16'($urandom_range(0, 3)));
    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0: begin
          b = 8'($urandom);
          if (b == 8'hA5) b = 8'h5A;
          send_gap(b, 1);
        end
        1: begin
          send_gap(8'hA5, 1);
          b = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(17, 255));
          send_gap(b, 1);
        end
        2: rand_packet(1'b1, 1'b0);
        3: begin load(16'($urandom_range(0, 3))); wait_cyc(1); end
        4: rand_packet(1'b0, 1'b1);
        default: begin rand_packet(1'b0, 1'b0); hold_and_release(); end
      endcase
    end
    wait_cyc(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
